// File: rtl/iob_cache_be_arbiter.sv
// rtl/iob_cache_be_arbiter.sv - round-robin arbiter sharing one back-end IOb port between N cache back-ends (optional IOB_CACHE_BE_ARB_LOCK_EN)
module iob_cache_be_arbiter #(
  parameter int N_MGR   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int OUTST_W = 2
) (
  input  logic                        clk_i,
  input  logic                        cke_i,
  input  logic                        arst_i,
  input  logic [N_MGR-1:0]            m_iob_valid_i,
  input  logic [N_MGR*ADDR_W-1:0]     m_iob_addr_i,
  input  logic [N_MGR*DATA_W-1:0]     m_iob_wdata_i,
  input  logic [N_MGR*DATA_W/8-1:0]   m_iob_wstrb_i,
  output logic [N_MGR-1:0]            m_iob_ready_o,
  output logic [N_MGR-1:0]            m_iob_rvalid_o,
  output logic [DATA_W-1:0]           m_iob_rdata_o,
  output logic                        be_iob_valid_o,
  output logic [ADDR_W-1:0]           be_iob_addr_o,
  output logic [DATA_W-1:0]           be_iob_wdata_o,
  output logic [DATA_W/8-1:0]         be_iob_wstrb_o,
  input  logic                        be_iob_rvalid_i,
  input  logic [DATA_W-1:0]           be_iob_rdata_i,
  input  logic                        be_iob_ready_i,
  output logic [OUTST_W:0]            outst_o,
  output logic                        err_o
);

  localparam int ID_W   = (N_MGR > 1) ? $clog2(N_MGR) : 1;
  localparam int DEPTH  = 2 ** OUTST_W;
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    fifo_q [DEPTH];
  logic [OUTST_W-1:0] wr_q, rd_q;
  logic [OUTST_W:0]   cnt_q, cnt_d;
  logic               err_q;

  logic               full, empty;
  logic               rr_vld, gnt_vld;
  logic [ID_W-1:0]    rr_id, gnt_id, arb_idx, head;
  logic               accept, push, pop;

  assign full  = (cnt_q == (OUTST_W+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_q];

  // Round-robin search: first valid manager starting at ptr, wrapping modulo N_MGR
  always_comb begin
    rr_vld  = 1'b0;
    rr_id   = '0;
    arb_idx = '0;
    for (int i = 0; i < N_MGR; i++) begin
      arb_idx = ID_W'((int'(ptr_q) + i) % N_MGR);
      if (!rr_vld && m_iob_valid_i[arb_idx]) begin
        rr_vld = 1'b1;
        rr_id  = arb_idx;
      end
    end
  end

`ifdef IOB_CACHE_BE_ARB_LOCK_EN
  logic            lock_q, lock_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;
  logic            lock_hold;

  // The lock only holds while the locked manager keeps valid asserted
  assign lock_hold = lock_q & m_iob_valid_i[lock_id_q];
  assign gnt_id    = lock_hold ? lock_id_q : rr_id;
  assign gnt_vld   = (lock_hold | rr_vld) & ~full & ~arst_i;

  // Lock onto the manager that was just accepted; drop it once its valid falls
  always_comb begin
    lock_d    = lock_hold;
    lock_id_d = lock_id_q;
    if (accept) begin
      lock_d    = 1'b1;
      lock_id_d = gnt_id;
    end
  end

  // Lock state register
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (cke_i) begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`else
  assign gnt_id  = rr_id;
  assign gnt_vld = rr_vld & ~full & ~arst_i;
`endif

  // Forward the granted manager's request; everything is zero without a grant
  always_comb begin
    be_iob_valid_o = gnt_vld;
    be_iob_addr_o  = '0;
    be_iob_wdata_o = '0;
    be_iob_wstrb_o = '0;
    m_iob_ready_o  = '0;
    if (gnt_vld) begin
      be_iob_addr_o         = m_iob_addr_i[int'(gnt_id)*ADDR_W +: ADDR_W];
      be_iob_wdata_o        = m_iob_wdata_i[int'(gnt_id)*DATA_W +: DATA_W];
      be_iob_wstrb_o        = m_iob_wstrb_i[int'(gnt_id)*STRB_W +: STRB_W];
      m_iob_ready_o[gnt_id] = be_iob_ready_i;
    end
  end

  assign accept = gnt_vld & be_iob_ready_i;
  assign push   = accept & ~(|be_iob_wstrb_o);
  assign pop    = be_iob_rvalid_i & ~empty & ~arst_i;

  // Route a read response to the manager at the head of the ID FIFO
  always_comb begin
    m_iob_rvalid_o = '0;
    if (pop) m_iob_rvalid_o[head] = 1'b1;
  end

  assign m_iob_rdata_o = be_iob_rdata_i;

  // Next pointer and outstanding count
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (gnt_id == ID_W'(N_MGR-1)) ? '0 : gnt_id + ID_W'(1);
    cnt_d = cnt_q + (OUTST_W+1)'(push) - (OUTST_W+1)'(pop);
  end

  // Arbiter pointer, ID FIFO and sticky error register
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (cke_i) begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (push) begin
        fifo_q[wr_q] <= gnt_id;
        wr_q         <= wr_q + OUTST_W'(1);
      end
      if (pop) rd_q <= rd_q + OUTST_W'(1);
      if (be_iob_rvalid_i && empty) err_q <= 1'b1;
    end
  end

  assign outst_o = cnt_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// tb/tb_iob_cache_be_arbiter.sv - self-checking bench for iob_cache_be_arbiter
module tb_iob_cache_be_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic [1:0]  m_valid;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_ready;
  logic [1:0]  m_rvalid;
  logic [31:0] m_rdata;
  logic        be_valid;
  logic [31:0] be_addr;
  logic [31:0] be_wdata;
  logic [3:0]  be_wstrb;
  logic        be_rvalid;
  logic [31:0] be_rdata;
  logic        be_ready;
  logic [2:0]  outst;
  logic        err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int q[$];

  always #5 clk = ~clk;

  iob_cache_be_arbiter dut (
    .clk_i(clk), .cke_i(1'b1), .arst_i(arst),
    .m_iob_valid_i(m_valid), .m_iob_addr_i(m_addr), .m_iob_wdata_i(m_wdata),
    .m_iob_wstrb_i(m_wstrb), .m_iob_ready_o(m_ready), .m_iob_rvalid_o(m_rvalid),
    .m_iob_rdata_o(m_rdata), .be_iob_valid_o(be_valid), .be_iob_addr_o(be_addr),
    .be_iob_wdata_o(be_wdata), .be_iob_wstrb_o(be_wstrb), .be_iob_rvalid_i(be_rvalid),
    .be_iob_rdata_i(be_rdata), .be_iob_ready_i(be_ready), .outst_o(outst), .err_o(err)
  );

  typedef struct {
    logic [1:0] v;
    logic [1:0] w;
    logic       rdy;
    logic       rv;
    logic [1:0] e_rdy;
    logic       e_bev;
    logic       e_g;
    logic [2:0] e_outst;
    logic       e_err;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic rdy,
                       input logic rv, input logic [31:0] rd);
    m_valid   = v;
    m_wstrb   = {w[1] ? 4'hF : 4'h0, w[0] ? 4'hF : 4'h0};
    be_ready  = rdy;
    be_rvalid = rv;
    be_rdata  = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side of a response: pop the expected issuer if a response is driven
  task automatic sb_rsp(input string name, input logic rv, input logic [31:0] rd);
    int h;
    if (rv && q.size() > 0) begin
      h = q.pop_front();
      chk({name, "_rvalid"}, 64'(m_rvalid), 64'(2'b01 << h));
      chk({name, "_rdata"}, 64'(m_rdata), 64'(rd));
    end else begin
      chk({name, "_rvalid"}, 64'(m_rvalid), 64'd0);
    end
  endtask

  task automatic do_reset(input string name);
    arst = 1'b1;
    drive(2'b11, 2'b00, 1'b1, 1'b1, 32'h0);
    #2;
    chk({name, "_rst_bev"}, 64'(be_valid), 64'd0);
    chk({name, "_rst_ready"}, 64'(m_ready), 64'd0);
    chk({name, "_rst_rvalid"}, 64'(m_rvalid), 64'd0);
    tick();
    arst = 1'b0;
    drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
    q.delete();
    #2;
    chk({name, "_outst"}, 64'(outst), 64'd0);
    chk({name, "_err"}, 64'(err), 64'd0);
    chk({name, "_bev"}, 64'(be_valid), 64'd0);
    tick();
  endtask

  initial begin
    int exp_seq[8];
    int cnt[2];
    int n;
    int g;
    logic [31:0] rd;
    logic rv;

`ifdef IOB_CACHE_BE_ARB_LOCK_EN
    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    //             v      w      rdy   rv    e_rdy  bev   g     outst  err
    tbl[0]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[2]  = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 3'd2, 1'b0};
    tbl[3]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'd1, 1'b0};
    tbl[4]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[5]  = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[6]  = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd0, 1'b0};
    tbl[7]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 3'd1, 1'b0};
    tbl[8]  = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'd2, 1'b0};
    tbl[9]  = '{2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 3'd2, 1'b0};
    tbl[10] = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[11] = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 3'd4, 1'b0};
    tbl[12] = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd4, 1'b0};
    tbl[13] = '{2'b01, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'd3, 1'b0};
    tbl[14] = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'd4, 1'b0};
    tbl[15] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'd3, 1'b0};
    tbl[16] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'd2, 1'b0};
    tbl[17] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'd1, 1'b0};
    tbl[18] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[19] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[20] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1};

    m_addr  = {32'h0000_0200, 32'h0000_0100};
    m_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    arst    = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    tick();

    do_reset("init");

    // Table: grant, stall, write, response routing, empty-FIFO error
    for (int i = 0; i < 21; i++) begin
      rd = 32'hD000_0000 + 32'(i);
      drive(tbl[i].v, tbl[i].w, tbl[i].rdy, tbl[i].rv, rd);
      #2;
      sb_rsp($sformatf("row%0d", i), tbl[i].rv, rd);
      chk($sformatf("row%0d_ready", i), 64'(m_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("row%0d_bev", i), 64'(be_valid), 64'(tbl[i].e_bev));
      if (tbl[i].e_bev) begin
        chk($sformatf("row%0d_addr", i), 64'(be_addr), tbl[i].e_g ? 64'h200 : 64'h100);
        chk($sformatf("row%0d_wstrb", i), 64'(be_wstrb), tbl[i].w[tbl[i].e_g] ? 64'hF : 64'h0);
      end else begin
        chk($sformatf("row%0d_wstrb0", i), 64'(be_wstrb), 64'h0);
      end
      for (int k = 0; k < 2; k++)
        if (tbl[i].e_rdy[k] && !tbl[i].w[k]) q.push_back(k);
      tick();
      chk($sformatf("row%0d_outst", i), 64'(outst), 64'(tbl[i].e_outst));
      chk($sformatf("row%0d_err", i), 64'(err), 64'(tbl[i].e_err));
    end

    // Both managers hold valid for 4 reads each; responses returned every cycle
    do_reset("rr");
    cnt = '{0, 0};
    n = 0;
    for (int c = 0; c < 20 && n < 8; c++) begin
      rv = (q.size() > 0);
      rd = 32'hC000_0000 + 32'(c);
      drive({cnt[1] < 4, cnt[0] < 4}, 2'b00, 1'b1, rv, rd);
      #2;
      sb_rsp($sformatf("rr%0d", c), rv, rd);
      g = (m_ready == 2'b01) ? 0 : (m_ready == 2'b10) ? 1 : -1;
      chk($sformatf("rr%0d_grant", c), 64'(g), 64'(exp_seq[n]));
      q.push_back(exp_seq[n]);
      cnt[exp_seq[n]]++;
      n++;
      tick();
    end
    chk("rr_count", 64'(n), 64'd8);
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      rd = 32'hE000_0000 + 32'(c);
      drive(2'b00, 2'b00, 1'b1, 1'b1, rd);
      #2;
      sb_rsp($sformatf("drain%0d", c), 1'b1, rd);
      tick();
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
    tick();
    chk("rr_outst_drained", 64'(outst), 64'd0);

    // Reset with two reads outstanding; the next response hits an empty FIFO
    do_reset("mid");
    drive(2'b01, 2'b00, 1'b1, 1'b0, 32'h0);
    tick();
    drive(2'b10, 2'b00, 1'b1, 1'b0, 32'h0);
    tick();
    chk("mid_outst2", 64'(outst), 64'd2);
    arst = 1'b1;
    drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
    tick();
    arst = 1'b0;
    q.delete();
    chk("mid_outst0", 64'(outst), 64'd0);
    chk("mid_err0", 64'(err), 64'd0);
    drive(2'b00, 2'b00, 1'b1, 1'b1, 32'h1234_5678);
    #2;
    sb_rsp("mid_late", 1'b1, 32'h1234_5678);
    tick();
    chk("mid_err1", 64'(err), 64'd1);
    drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
    tick();
    chk("mid_err_sticky", 64'(err), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
